// File: rtl/mem_if_pkg.sv
// Shared memory-line protocol definitions used by the arbiter, the cache
// dummies and the DDR2 wrapper.
package mem_if_pkg;

    localparam int MEM_ADDR_W = 28;
    localparam int MEM_DATA_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  rw;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; remembers the last grant and advances it
// only when the caller accepts the pick.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    input  logic en_i,
    output logic gnt_o,
    output logic any_o
);

    logic last_q, last_d;

    always_comb begin
        any_o = req0_i | req1_i;
        // On a tie, favour whichever port was not served last.
        if (req0_i && req1_i) gnt_o = ~last_q;
        else                  gnt_o = req1_i;
        last_d = last_q;
        if (en_i && any_o) last_d = gnt_o;
    end

    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates icache (p0) and dcache (p1) line requests onto one DDR2 port,
// one outstanding transaction at a time, with a sticky downstream timeout flag.
module mem_port_arbiter
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_valid,
    input  logic                  p0_rw,
    input  logic [MEM_ADDR_W-1:0] p0_addr,
    input  logic [MEM_DATA_W-1:0] p0_wdata,
    output logic                  p0_ready,
    output logic [MEM_DATA_W-1:0] p0_rdata,
    input  logic                  p1_valid,
    input  logic                  p1_rw,
    input  logic [MEM_ADDR_W-1:0] p1_addr,
    input  logic [MEM_DATA_W-1:0] p1_wdata,
    output logic                  p1_ready,
    output logic [MEM_DATA_W-1:0] p1_rdata,
    output logic                  ds_valid,
    output logic                  ds_rw,
    output logic [MEM_ADDR_W-1:0] ds_addr,
    output logic [MEM_DATA_W-1:0] ds_wdata,
    input  logic                  ds_ready,
    input  logic [MEM_DATA_W-1:0] ds_rdata,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam logic [15:0] TO_W = 16'(TIMEOUT_CYCLES);

    arb_state_e            state_q, state_d;
    mem_req_t              req_q, req_d;
    logic                  gnt_q, gnt_d;
    logic [MEM_DATA_W-1:0] rdata_q, rdata_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  tout_q, tout_d;
    logic                  rdy0_q, rdy0_d;
    logic                  rdy1_q, rdy1_d;
    logic                  dsv_q, dsv_d;
    logic                  busy_q, busy_d;
    logic                  arb_gnt, arb_any;

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req0_i (p0_valid),
        .req1_i (p1_valid),
        .en_i   (state_q == ST_IDLE),
        .gnt_o  (arb_gnt),
        .any_o  (arb_any)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        gnt_d   = gnt_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        tout_d  = tout_q;
        rdy0_d  = 1'b0;
        rdy1_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    req_d   = arb_gnt ? mem_req_t'{p1_rw, p1_addr, p1_wdata}
                                      : mem_req_t'{p0_rw, p0_addr, p0_wdata};
                    gnt_d   = arb_gnt;
                    cnt_d   = 16'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Counter saturates so a very long stall cannot re-trigger by wrapping.
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                if (TO_W != 16'd0 && cnt_d == TO_W) tout_d = 1'b1;
                if (ds_ready) begin
                    state_d = ST_RESP;
                    if (!req_q.rw) rdata_d = ds_rdata;
                    if (gnt_q) rdy1_d = 1'b1;
                    else       rdy0_d = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        dsv_d  = (state_d == ST_BUSY);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            gnt_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= 16'd0;
            tout_q  <= 1'b0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            dsv_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            gnt_q   <= gnt_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
            dsv_q   <= dsv_d;
            busy_q  <= busy_d;
        end
    end

    assign ds_valid    = dsv_q;
    assign ds_rw       = req_q.rw;
    assign ds_addr     = req_q.addr;
    assign ds_wdata    = req_q.wdata;
    assign p0_ready    = rdy0_q;
    assign p1_ready    = rdy1_q;
    assign p0_rdata    = rdata_q;
    assign p1_rdata    = rdata_q;
    assign busy        = busy_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected
// downstream issues and upstream responses; monitors pop and compare.
module tb_mem_port_arbiter;
    import mem_if_pkg::*;

    typedef struct {
        int           port;
        logic [255:0] data;
    } resp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         p0_valid = 1'b0, p0_rw = 1'b0;
    logic [27:0]  p0_addr = '0;
    logic [255:0] p0_wdata = '0;
    logic         p1_valid = 1'b0, p1_rw = 1'b0;
    logic [27:0]  p1_addr = '0;
    logic [255:0] p1_wdata = '0;
    logic         ds_ready = 1'b0;
    logic [255:0] ds_rdata = '0;
    logic         p0_ready, p1_ready, ds_valid, ds_rw, busy, timeout_err;
    logic [255:0] p0_rdata, p1_rdata, ds_wdata;
    logic [27:0]  ds_addr;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    mem_req_t exp_req[$];
    resp_t    exp_resp[$];

    localparam logic [255:0] RD1 = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
    localparam logic [255:0] RD2 = 256'hCAFEF00D_00000001_00000002_00000003_00000004_00000005_00000006_DEADBEEF;
    localparam logic [255:0] WD  = {32{8'hA5}};

    mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ready(p0_ready), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ready(p1_ready), .p1_rdata(p1_rdata),
        .ds_valid(ds_valid), .ds_rw(ds_rw), .ds_addr(ds_addr), .ds_wdata(ds_wdata),
        .ds_ready(ds_ready), .ds_rdata(ds_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Downstream-issue and upstream-response monitors
    logic prev_dsv = 1'b0;
    initial begin
        mem_req_t er;
        resp_t    rr;
        forever begin
            @(negedge clk);
            if (ds_valid && !prev_dsv) begin
                if (exp_req.size() == 0) begin
                    chk("unexpected_ds_req", {228'd0, ds_addr}, 256'd0 - 1);
                end else begin
                    er = exp_req.pop_front();
                    chk("ds_rw", {255'd0, ds_rw}, {255'd0, er.rw});
                    chk("ds_addr", {228'd0, ds_addr}, {228'd0, er.addr});
                    chk("ds_wdata", ds_wdata, er.wdata);
                end
            end
            prev_dsv = ds_valid;
            if (p0_ready || p1_ready) begin
                chk("single_ready", {254'd0, p1_ready, p0_ready}, p1_ready ? 256'd2 : 256'd1);
                if (exp_resp.size() == 0) begin
                    chk("unexpected_ready", {254'd0, p1_ready, p0_ready}, 256'd0);
                end else begin
                    rr = exp_resp.pop_front();
                    chk("resp_port", p1_ready ? 256'd1 : 256'd0, 256'(rr.port));
                    chk("resp_rdata", p1_ready ? p1_rdata : p0_rdata, rr.data);
                end
            end
        end
    end

    task automatic wait_dsv(output int found_cyc);
        int n = 0;
        while (!ds_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        found_cyc = cyc;
        chk("ds_valid_seen", {255'd0, ds_valid}, 256'd1);
    endtask

    // Waits for the issue, answers after lat BUSY cycles, returns who got ready.
    task automatic serve(input int lat, input logic [255:0] d, output int who, output int rise);
        wait_dsv(rise);
        repeat (lat - 1) @(negedge clk);
        ds_ready = 1'b1;
        ds_rdata = d;
        @(negedge clk);
        ds_ready = 1'b0;
        ds_rdata = {8{32'h0BAD0BAD}};
        who = p0_ready ? 0 : (p1_ready ? 1 : -1);
        chk("ds_valid_drop", {255'd0, ds_valid}, 256'd0);
    endtask

    initial begin
        int who, r1, r2, dummy;
        logic [255:0] d;

        repeat (3) @(negedge clk);
        chk("rst_ds_valid", {255'd0, ds_valid}, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_timeout", {255'd0, timeout_err}, 256'd0);
        chk("rst_readies", {254'd0, p1_ready, p0_ready}, 256'd0);
        chk("rst_ds_addr", {228'd0, ds_addr}, 256'd0);
        chk("rst_rdata", p0_rdata, 256'd0);
        rst = 1'b0;

        // Single read on p0, then back-to-back read the cycle after ready
        exp_req.push_back('{1'b0, 28'h0001010, 256'd0});
        exp_resp.push_back('{0, RD1});
        exp_req.push_back('{1'b0, 28'h0001018, 256'd0});
        exp_resp.push_back('{0, RD2});
        @(posedge clk); #1;
        p0_valid = 1'b1; p0_rw = 1'b0; p0_addr = 28'h0001010;
        serve(1, RD1, who, r1);
        chk("single_owner", 256'(who), 256'd0);
        @(posedge clk); #1;
        p0_addr = 28'h0001018;
        serve(1, RD2, who, r2);
        chk("b2b_owner", 256'(who), 256'd0);
        chk("b2b_spacing", 256'(r2 - r1), 256'd3);
        @(posedge clk); #1;
        p0_valid = 1'b0;

        // Write on p1: rdata keeps the previous read value
        exp_req.push_back('{1'b1, 28'h2000000, WD});
        exp_resp.push_back('{1, RD2});
        p1_valid = 1'b1; p1_rw = 1'b1; p1_addr = 28'h2000000; p1_wdata = WD;
        serve(2, RD1, who, dummy);
        chk("write_owner", 256'(who), 256'd1);
        @(posedge clk); #1;
        p1_valid = 1'b0; p1_rw = 1'b0; p1_wdata = '0;

        // Tie: both held valid, expect p0,p1,p0,p1
        repeat (2) @(negedge clk);
        exp_req.push_back('{1'b0, 28'h0000100, 256'd0});
        exp_req.push_back('{1'b0, 28'h0000200, 256'd0});
        exp_req.push_back('{1'b0, 28'h0000101, 256'd0});
        exp_req.push_back('{1'b0, 28'h0000201, 256'd0});
        for (int i = 0; i < 4; i++) exp_resp.push_back('{i % 2, {8{32'hD0000000 + 32'(i)}}});
        @(posedge clk); #1;
        p0_valid = 1'b1; p0_addr = 28'h0000100;
        p1_valid = 1'b1; p1_addr = 28'h0000200;
        for (int i = 0; i < 4; i++) begin
            d = {8{32'hD0000000 + 32'(i)}};
            serve(1 + i % 3, d, who, dummy);
            chk("tie_owner", 256'(who), 256'(i % 2));
            @(posedge clk); #1;
            if (who == 0) begin
                if (i < 2) p0_addr = 28'h0000101; else p0_valid = 1'b0;
            end else if (who == 1) begin
                if (i < 2) p1_addr = 28'h0000201; else p1_valid = 1'b0;
            end
        end
        p0_valid = 1'b0; p1_valid = 1'b0;

        // Stray ds_ready in IDLE must be ignored
        repeat (2) @(negedge clk);
        ds_ready = 1'b1;
        @(negedge clk);
        ds_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_ready_busy", {255'd0, busy}, 256'd0);
        chk("stray_ready_pulse", {254'd0, p1_ready, p0_ready}, 256'd0);

        // Timeout with TIMEOUT_CYCLES=8, late completion
        exp_req.push_back('{1'b0, 28'h3000000, 256'd0});
        exp_resp.push_back('{0, RD1});
        @(posedge clk); #1;
        p0_valid = 1'b1; p0_addr = 28'h3000000;
        wait_dsv(dummy);
        chk("to_busy", {255'd0, busy}, 256'd1);
        repeat (7) @(negedge clk);
        chk("to_before", {255'd0, timeout_err}, 256'd0);
        @(negedge clk);
        chk("to_after", {255'd0, timeout_err}, 256'd1);
        repeat (3) @(negedge clk);
        chk("to_still_waiting", {255'd0, ds_valid}, 256'd1);
        ds_ready = 1'b1; ds_rdata = RD1;
        @(negedge clk);
        ds_ready = 1'b0;
        chk("to_late_ready", {255'd0, p0_ready}, 256'd1);
        chk("to_sticky", {255'd0, timeout_err}, 256'd1);
        @(posedge clk); #1;
        p0_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("to_sticky_idle", {255'd0, timeout_err}, 256'd1);

        // Reset on the third BUSY cycle abandons the request
        exp_req.push_back('{1'b0, 28'h4000000, 256'd0});
        @(posedge clk); #1;
        p0_valid = 1'b1; p0_addr = 28'h4000000;
        wait_dsv(dummy);
        repeat (2) @(negedge clk);
        rst = 1'b1; p0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rstbusy_ds_valid", {255'd0, ds_valid}, 256'd0);
        chk("rstbusy_busy", {255'd0, busy}, 256'd0);
        chk("rstbusy_timeout", {255'd0, timeout_err}, 256'd0);
        chk("rstbusy_ready", {254'd0, p1_ready, p0_ready}, 256'd0);
        repeat (3) @(negedge clk);
        chk("rstbusy_no_ready", {254'd0, p1_ready, p0_ready}, 256'd0);

        // After reset, a tie goes to p0 first
        exp_req.push_back('{1'b0, 28'h5000000, 256'd0});
        exp_req.push_back('{1'b0, 28'h5000001, 256'd0});
        exp_resp.push_back('{0, RD2});
        exp_resp.push_back('{1, RD1});
        @(posedge clk); #1;
        p0_valid = 1'b1; p0_addr = 28'h5000000;
        p1_valid = 1'b1; p1_addr = 28'h5000001;
        serve(1, RD2, who, dummy);
        chk("post_rst_first", 256'(who), 256'd0);
        @(posedge clk); #1;
        p0_valid = 1'b0;
        serve(1, RD1, who, dummy);
        chk("post_rst_second", 256'(who), 256'd1);
        @(posedge clk); #1;
        p1_valid = 1'b0;

        repeat (4) @(negedge clk);
        chk("req_queue_empty", 256'(exp_req.size()), 256'd0);
        chk("resp_queue_empty", 256'(exp_resp.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port request arbiter between the instruction-cache and data-cache memory ports and the single DDR2 controller port. Each upstream port uses the 256-bit line protocol: valid/rw/28-bit address/256-bit write data, answered by a one-cycle ready pulse carrying read data. The arbiter registers one request at a time and forwards it downstream on the same protocol. It returns the response to the requester, alternates grants round-robin, and flags downstream timeouts.

## Interface
- TIMEOUT_CYCLES, default 1023: BUSY cycles without ds_ready before timeout_err is set; 0 disables the check.
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- p0_valid, p0_rw  in  1 each  icache request valid; rw=1 write, rw=0 read
- p0_addr  in  28  icache line address
- p0_wdata  in  256  icache write data
- p0_ready  out  1  one-cycle completion pulse to icache
- p0_rdata  out  256  read data, meaningful while p0_ready=1
- p1_valid, p1_rw, p1_addr, p1_wdata, p1_ready, p1_rdata  same widths/meaning, dcache port
- ds_valid, ds_rw  out  1 each  downstream request
- ds_addr  out  28  downstream address
- ds_wdata  out  256  downstream write data
- ds_ready  in  1  downstream completion pulse
- ds_rdata  in  256  downstream read data, valid with ds_ready
- busy  out  1  high in BUSY or RESP
- timeout_err  out  1  sticky timeout flag

## Operation
- Upstream rule: a requester holds valid/rw/addr/wdata stable until its ready pulse. valid high in any cycle after the ready cycle is a new request.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If neither port is valid, stay in IDLE.
  - If exactly one port is valid, grant it.
  - If both are valid, grant the port not granted last. last_grant resets to 1, so p0 wins the first tie.
  - On a grant: capture rw/addr/wdata into the request register; record gnt and update last_grant; go to BUSY.
- BUSY:
  - ds_valid=1 with the captured request.
  - On ds_ready, go to RESP. If the request was a read, capture ds_rdata into rdata_q. On writes rdata_q is unchanged.
- RESP:
  - Pulse the granted port's ready; ds_valid=0.
  - Do not sample upstream valid (the requester still shows the old request); go to IDLE.
- p0_rdata and p1_rdata are both driven from rdata_q.
- ds_ready outside BUSY is ignored.
- Timeout:
  - A 16-bit counter clears on entry to BUSY and increments every BUSY cycle.
  - When it reaches TIMEOUT_CYCLES (non-zero), timeout_err is set. It stays set until rst.
  - The transaction keeps waiting and completes normally if ds_ready arrives later.
- Reset values: state IDLE; ds_valid, ds_rw, p0_ready, p1_ready, busy, timeout_err all 0; ds_addr, ds_wdata, rdata_q 0; last_grant 1; counter 0.
- Reset mid-transaction abandons the request. ds_valid is 0 from the cycle after rst is sampled, and no ready pulse is issued.

## Timing
- All outputs are registered.
- Request sampled in IDLE at cycle T: ds_valid=1 from T+1.
- ds_ready at cycle N: pX_ready=1 and pX_rdata valid at N+1 only; ds_valid=0 at N+1; IDLE at N+2.
- Fastest transaction: ds_ready at T+1, ready at T+2, next sample at T+3. Minimum spacing is 3 cycles per request.
- A requester that re-asserts valid at N+2 (new request) is eligible in that IDLE cycle. Round-robin still applies if the other port is waiting.
- Simultaneous p0/p1 valid in IDLE: exactly one grant, the other port waits with no loss.

## Structure
- Shared package (mem_if_pkg): MEM_ADDR_W=28, MEM_DATA_W=256, FSM state encoding, request struct {rw, addr, wdata}. These are reused by the cache dummies and the DDR2 wrapper.
- One natural sub-module: rr_arb2 (two-requester round-robin picker holding last_grant, with an update enable). Everything else stays in the top level.

## Test plan
- Single read: p0_valid=1, rw=0, addr=28'h0001010 → ds_valid next cycle with ds_addr=28'h0001010. Drive ds_ready with ds_rdata=256'h1111…8888 → p0_ready one cycle, p0_rdata=256'h1111…8888, p1_ready stays 0.
- Tie after reset: p0 and p1 both held valid → grant order p0, p1, p0, p1 across four transactions; each ready goes only to its owner.
- Back-to-back: p0 re-asserts valid the cycle after ready with addr=28'h0001018 → the new address appears on ds_addr, the stale 28'h0001010 is never reissued, spacing is 3 cycles.
- Write: p1 rw=1, addr=28'h2000000, wdata=256'hA5…A5 → ds_rw=1 and ds_wdata matches; p1_ready pulses; rdata_q keeps the previous read value.
- Timeout: TIMEOUT_CYCLES=8, ds_ready withheld → timeout_err rises after the 8th BUSY cycle and stays set. A later ds_ready completes the request with timeout_err still 1.
- Reset in BUSY: rst at cycle 3 of BUSY → ds_valid=0 next cycle, no ready pulse, timeout_err=0. The next request after reset is granted p0-first.
